// File: rtl/lsu_byte_master.sv
// Byte-serial load/store initiator: splits one MEM-stage access into little-endian byte beats.
// Optional macro LSU_MISALIGN_SPLIT_EN lets misaligned halfword/word accesses run as byte beats.
module lsu_byte_master #(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned ACK_TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_wr,
    input  logic [3:0]        req_rd,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [31:0]       rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_re,
    output logic              mem_we,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata,
    input  logic              mem_ack
);
    localparam logic [1:0] DMWR_NOP = 2'b00;
    localparam logic [1:0] DMWR_SW  = 2'b01;
    localparam logic [1:0] DMWR_SH  = 2'b10;
    localparam logic [3:0] DMRD_NOP = 4'b0000;
    localparam logic [3:0] DMRD_LW  = 4'b0001;
    localparam logic [3:0] DMRD_LH  = 4'b0010;
    localparam logic [3:0] DMRD_LHU = 4'b0011;
    localparam logic [3:0] DMRD_LB  = 4'b0100;
    localparam logic [3:0] DMRD_LBU = 4'b0101;

    typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

    state_e            state_q, state_d;
    logic              is_ld_q, is_ld_d;
    logic [3:0]        rd_q, rd_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [1:0]        k_q, k_d;
    logic [1:0]        last_q, last_d;
    logic              gap_q, gap_d;
    logic [31:0]       tmo_q, tmo_d;
    logic [31:0]       buf_q, buf_d;
    logic              err_q, err_d;
    logic [31:0]       rdata_q, rdata_d;

    logic       in_ld, in_st, in_word, in_half, in_fault, strobe;
    logic [1:0] in_last;
    logic [31:0] ld_word, ld_ext;

    always_comb begin
        in_ld   = (req_rd != DMRD_NOP);
        in_st   = (req_wr != DMWR_NOP);
        in_word = (req_rd == DMRD_LW) || (req_wr == DMWR_SW);
        in_half = (req_rd == DMRD_LH) || (req_rd == DMRD_LHU) || (req_wr == DMWR_SH);
        in_last = in_word ? 2'd3 : (in_half ? 2'd1 : 2'd0);
        in_fault = (in_ld && in_st) || (req_rd > DMRD_LBU);
`ifndef LSU_MISALIGN_SPLIT_EN
        if ((in_half && req_addr[0]) || (in_word && (req_addr[1:0] != 2'b00))) begin
            in_fault = 1'b1;
        end
`endif
    end

    // Final load word includes the byte arriving with the last ack.
    always_comb begin
        ld_word = buf_q;
        ld_word[{k_q, 3'b000} +: 8] = mem_rdata;
        unique case (rd_q)
            DMRD_LB:  ld_ext = {{24{ld_word[7]}}, ld_word[7:0]};
            DMRD_LBU: ld_ext = {24'b0, ld_word[7:0]};
            DMRD_LH:  ld_ext = {{16{ld_word[15]}}, ld_word[15:0]};
            DMRD_LHU: ld_ext = {16'b0, ld_word[15:0]};
            default:  ld_ext = ld_word;
        endcase
    end

    assign strobe = (state_q == StAccess) && !gap_q;

    always_comb begin
        state_d = state_q;
        is_ld_d = is_ld_q;
        rd_d    = rd_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        k_d     = k_q;
        last_d  = last_q;
        gap_d   = gap_q;
        tmo_d   = tmo_q;
        buf_d   = buf_q;
        err_d   = err_q;
        rdata_d = rdata_q;
        unique case (state_q)
            StIdle: begin
                if (req_valid && (in_ld || in_st)) begin
                    is_ld_d = in_ld;
                    rd_d    = req_rd;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    last_d  = in_last;
                    k_d     = 2'd0;
                    gap_d   = 1'b0;
                    tmo_d   = 32'd0;
                    err_d   = in_fault;
                    state_d = in_fault ? StDone : StAccess;
                end
            end
            StAccess: begin
                if (gap_q) begin
                    gap_d = 1'b0;
                end else if (mem_ack) begin
                    tmo_d = 32'd0;
                    buf_d = ld_word;
                    if (k_q == last_q) begin
                        state_d = StDone;
                        if (is_ld_q) begin
                            rdata_d = ld_ext;
                        end
                    end else begin
                        k_d   = k_q + 2'd1;
                        gap_d = 1'b1;
                    end
                end else if ((ACK_TIMEOUT != 0) && (tmo_q == ACK_TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = StDone;
                end else begin
                    tmo_d = tmo_q + 32'd1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            is_ld_q <= 1'b0;
            rd_q    <= DMRD_NOP;
            addr_q  <= '0;
            wdata_q <= 32'd0;
            k_q     <= 2'd0;
            last_q  <= 2'd0;
            gap_q   <= 1'b0;
            tmo_q   <= 32'd0;
            buf_q   <= 32'd0;
            err_q   <= 1'b0;
            rdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            is_ld_q <= is_ld_d;
            rd_q    <= rd_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            k_q     <= k_d;
            last_q  <= last_d;
            gap_q   <= gap_d;
            tmo_q   <= tmo_d;
            buf_q   <= buf_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    assign req_ready = (state_q == StIdle);
    assign busy      = !req_ready;
    assign done      = (state_q == StDone);
    assign err       = done && err_q;
    assign rdata     = rdata_q;
    assign mem_re    = strobe && is_ld_q;
    assign mem_we    = strobe && !is_ld_q;
    assign mem_addr  = (state_q == StAccess) ? addr_q + ADDR_W'(k_q) : '0;
    assign mem_wdata = ((state_q == StAccess) && !is_ld_q) ? wdata_q[{k_q, 3'b000} +: 8] : 8'd0;

endmodule

// File: tb/tb_lsu_byte_master.sv
// Directed bench for lsu_byte_master with a byte memory model and programmable ack delay.
module tb_lsu_byte_master;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [1:0]  req_wr = 2'b00;
    logic [3:0]  req_rd = 4'b0000;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        busy, done, err;
    logic [31:0] rdata;
    logic [31:0] mem_addr;
    logic        mem_re, mem_we;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic        mem_ack;

    logic [7:0]  mem [0:1023];
    logic        ack_on = 1'b1;
    int          ack_delay = 0;
    int          wait_cnt = 0;
    int          strobe_cycles = 0;
    int          both_cnt = 0;
    int          done_cnt = 0;
    logic [31:0] rd_log[$];
    logic [31:0] wr_addr_log[$];
    logic [7:0]  wr_data_log[$];

    int n_checks = 0;
    int n_errors = 0;

    lsu_byte_master #(.ADDR_W(32), .ACK_TIMEOUT(15)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_wr    (req_wr),
        .req_rd    (req_rd),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .rdata     (rdata),
        .mem_addr  (mem_addr),
        .mem_re    (mem_re),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack)
    );

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr[9:0]];
    assign mem_ack   = (mem_re || mem_we) && ack_on && (wait_cnt >= ack_delay);

    always @(posedge clk) begin
        if ((mem_re || mem_we) && !mem_ack) wait_cnt <= wait_cnt + 1;
        else wait_cnt <= 0;
        if (mem_re || mem_we) strobe_cycles <= strobe_cycles + 1;
        if (mem_re && mem_we) both_cnt <= both_cnt + 1;
        if (done) done_cnt <= done_cnt + 1;
        if (mem_re && mem_ack) rd_log.push_back(mem_addr);
        if (mem_we && mem_ack) begin
            wr_addr_log.push_back(mem_addr);
            wr_data_log.push_back(mem_wdata);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic do_req(input logic [1:0] wr, input logic [3:0] rd, input logic [31:0] addr,
                          input logic [31:0] wdata, output int lat, output logic e);
        @(negedge clk);
        req_valid = 1'b1;
        req_wr    = wr;
        req_rd    = rd;
        req_addr  = addr;
        req_wdata = wdata;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        lat = 1;
        while (!done && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        e = err;
        check("done_seen", {31'b0, done}, 32'd1);
        @(posedge clk);
        #1;
    endtask

    int          lat, s0, r0, w0, d0;
    logic        e;
    logic [31:0] exp_rd;

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
        mem[10'h100] = 8'h11;
        mem[10'h101] = 8'h22;
        mem[10'h102] = 8'h33;
        mem[10'h103] = 8'h84;
        mem[10'h104] = 8'h55;
        mem[10'h105] = 8'h66;

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_ready", {31'b0, req_ready}, 32'd1);
        check("rst_busy_done_err", {29'b0, busy, done, err}, 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_strobes", {30'b0, mem_re, mem_we}, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_wdata", {24'b0, mem_wdata}, 32'd0);

        // LW 0x100, ack tied high
        r0 = rd_log.size();
        do_req(2'b00, 4'b0001, 32'h100, 32'd0, lat, e);
        check("lw_lat", lat, 32'd8);
        check("lw_err", {31'b0, e}, 32'd0);
        check("lw_rdata", rdata, 32'h84332211);
        check("lw_nbeats", rd_log.size() - r0, 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (r0 + i < rd_log.size()) check("lw_beat_addr", rd_log[r0 + i], 32'h100 + i);
        end

        do_req(2'b00, 4'b0100, 32'h103, 32'd0, lat, e);
        check("lb_lat", lat, 32'd2);
        check("lb_rdata", rdata, 32'hFFFFFF84);
        do_req(2'b00, 4'b0101, 32'h103, 32'd0, lat, e);
        check("lbu_rdata", rdata, 32'h00000084);
        do_req(2'b00, 4'b0010, 32'h102, 32'd0, lat, e);
        check("lh_lat", lat, 32'd4);
        check("lh_rdata", rdata, 32'hFFFF8433);
        do_req(2'b00, 4'b0011, 32'h102, 32'd0, lat, e);
        check("lhu_rdata", rdata, 32'h00008433);

        // SH with two wait cycles per beat
        ack_delay = 2;
        s0 = strobe_cycles;
        w0 = wr_addr_log.size();
        do_req(2'b10, 4'b0000, 32'h200, 32'hDEADBEEF, lat, e);
        ack_delay = 0;
        check("sh_lat", lat, 32'd8);
        check("sh_err", {31'b0, e}, 32'd0);
        check("sh_strobe_cycles", strobe_cycles - s0, 32'd6);
        check("sh_nwrites", wr_addr_log.size() - w0, 32'd2);
        if (wr_addr_log.size() >= w0 + 2) begin
            check("sh_addr0", wr_addr_log[w0], 32'h200);
            check("sh_data0", {24'b0, wr_data_log[w0]}, 32'hEF);
            check("sh_addr1", wr_addr_log[w0 + 1], 32'h201);
            check("sh_data1", {24'b0, wr_data_log[w0 + 1]}, 32'hBE);
        end
        check("sh_rdata_kept", rdata, 32'h00008433);

        // Misaligned LW
        s0 = strobe_cycles;
        do_req(2'b00, 4'b0001, 32'h102, 32'd0, lat, e);
`ifdef LSU_MISALIGN_SPLIT_EN
        check("mis_lat", lat, 32'd8);
        check("mis_err", {31'b0, e}, 32'd0);
        check("mis_rdata", rdata, 32'h66558433);
        exp_rd = 32'h66558433;
`else
        check("mis_lat", lat, 32'd1);
        check("mis_err", {31'b0, e}, 32'd1);
        check("mis_no_strobe", strobe_cycles - s0, 32'd0);
        check("mis_rdata_kept", rdata, 32'h00008433);
        exp_rd = 32'h00008433;
`endif

        // Store and load codes together, then an SB
        s0 = strobe_cycles;
        do_req(2'b01, 4'b0001, 32'h100, 32'h12345678, lat, e);
        check("both_lat", lat, 32'd1);
        check("both_err", {31'b0, e}, 32'd1);
        check("both_no_strobe", strobe_cycles - s0, 32'd0);
        check("both_rdata_kept", rdata, exp_rd);
        w0 = wr_addr_log.size();
        do_req(2'b11, 4'b0000, 32'h10, 32'h0000005A, lat, e);
        check("sb_lat", lat, 32'd2);
        check("sb_err", {31'b0, e}, 32'd0);
        check("sb_nwrites", wr_addr_log.size() - w0, 32'd1);
        if (wr_addr_log.size() > w0) begin
            check("sb_addr", wr_addr_log[w0], 32'h10);
            check("sb_data", {24'b0, wr_data_log[w0]}, 32'h5A);
        end

        // Unknown load code
        do_req(2'b00, 4'b0111, 32'h100, 32'd0, lat, e);
        check("badrd_err", {31'b0, e}, 32'd1);

        // Both NOP: nothing happens
        d0 = done_cnt;
        @(negedge clk);
        req_valid = 1'b1;
        req_wr    = 2'b00;
        req_rd    = 4'b0000;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        check("nop_ready", {31'b0, req_ready}, 32'd1);
        repeat (3) @(posedge clk);
        #1;
        check("nop_no_done", done_cnt - d0, 32'd0);

        // Reset during the third beat of an LW
        ack_delay = 1;
        d0 = done_cnt;
        @(negedge clk);
        req_valid = 1'b1;
        req_wr    = 2'b00;
        req_rd    = 4'b0001;
        req_addr  = 32'h100;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        lat = 0;
        while (!(mem_re && mem_addr == 32'h102) && lat < 50) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("rst_beat2_reached", {31'b0, mem_re}, 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        ack_delay = 0;
        check("midrst_ready", {31'b0, req_ready}, 32'd1);
        check("midrst_busy_done_err", {29'b0, busy, done, err}, 32'd0);
        check("midrst_strobes", {30'b0, mem_re, mem_we}, 32'd0);
        check("midrst_addr", mem_addr, 32'd0);
        check("midrst_rdata", rdata, 32'd0);
        repeat (4) @(posedge clk);
        #1;
        check("midrst_no_done", done_cnt - d0, 32'd0);

        // Ack never arrives
        ack_on = 1'b0;
        s0 = strobe_cycles;
        w0 = wr_addr_log.size();
        do_req(2'b11, 4'b0000, 32'h20, 32'h000000A5, lat, e);
        ack_on = 1'b1;
        check("tmo_lat", lat, 32'd16);
        check("tmo_err", {31'b0, e}, 32'd1);
        check("tmo_strobe_cycles", strobe_cycles - s0, 32'd15);
        check("tmo_no_write", wr_addr_log.size() - w0, 32'd0);
        check("tmo_strobe_low", {30'b0, mem_re, mem_we}, 32'd0);

        check("re_we_exclusive", both_cnt, 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end
endmodule
